// File: rtl/word_unpacker_pkg.sv
// word_unpacker_pkg: shared definitions for the word unpacker slice.
//   LANE_W_DEF / LANES_DEF : default lane width and lanes per packed word
//   state_t                : unpacker FSM state encoding
//   lane_lsb()             : bit offset of lane k inside a packed word
package word_unpacker_pkg;

    localparam int unsigned LANE_W_DEF = 4;
    localparam int unsigned LANES_DEF  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Lane k of a packed word lives at [lane_lsb(k, w) +: w].
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/word_unpacker_if.sv
// word_unpacker_if: both handshakes of the unpacker grouped in one bundle.
//   s_valid/s_ready/s_data/s_count : wide word input handshake
//   m_valid/m_ready/m_data/m_idx/m_last : narrow lane output handshake
//   bad_count                      : pulse flagging an out-of-range s_count
//   modport slave  : the unpacker side
//   modport master : the producer/consumer environment side
interface word_unpacker_if
    import word_unpacker_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned LANES  = LANES_DEF
);
    localparam int unsigned IN_W = LANE_W * LANES;
    localparam int unsigned CW   = $clog2(LANES + 1);

    logic              s_valid;
    logic              s_ready;
    logic [IN_W-1:0]   s_data;
    logic [CW-1:0]     s_count;
    logic              m_valid;
    logic              m_ready;
    logic [LANE_W-1:0] m_data;
    logic [CW-1:0]     m_idx;
    logic              m_last;
    logic              bad_count;

    modport slave (
        input  s_valid, s_data, s_count, m_ready,
        output s_ready, m_valid, m_data, m_idx, m_last, bad_count
    );

    modport master (
        output s_valid, s_data, s_count, m_ready,
        input  s_ready, m_valid, m_data, m_idx, m_last, bad_count
    );

endinterface

// File: rtl/word_unpacker_lane_select.sv
// lane_select: combinational LANES:1 mux picking one LANE_W-bit lane.
//   data : packed word (lane k at [k*LANE_W +: LANE_W])
//   idx  : lane index; out-of-range index yields zero
//   lane : selected lane
module lane_select
    import word_unpacker_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned CW     = $clog2(LANES + 1)
) (
    input  logic [LANE_W*LANES-1:0] data,
    input  logic [CW-1:0]           idx,
    output logic [LANE_W-1:0]       lane
);

    always_comb begin
        lane = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (idx == CW'(k)) begin
                lane = data[lane_lsb(k, LANE_W) +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/word_unpacker.sv
// word_unpacker: wide-to-narrow converter. Takes one packed word of LANES
// lanes and emits its valid lanes one per cycle, LSB lane first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : word_unpacker_if.slave carrying
//           s_valid/s_ready/s_data/s_count (word in),
//           m_valid/m_ready/m_data/m_idx/m_last (lane out),
//           bad_count (pulse after accepting a word with s_count 0 or >LANES)
module word_unpacker
    import word_unpacker_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned LANES  = LANES_DEF
) (
    input logic           clk,
    input logic           rst_n,
    word_unpacker_if.slave bus
);

    localparam int unsigned IN_W = LANE_W * LANES;
    localparam int unsigned CW   = $clog2(LANES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0] buf_q, buf_d;
    logic            bad_q, bad_d;

    logic            s_bad;
    logic [CW-1:0]   s_eff;
    logic            at_last;
    logic            accept;
    logic            m_fire;

    // Out-of-range counts are treated as a full word.
    assign s_bad   = (bus.s_count == '0) || (bus.s_count > CW'(LANES));
    assign s_eff   = s_bad ? CW'(LANES) : bus.s_count;

    // Gated by state so m_last stays 0 while idle and after reset.
    assign at_last = (state_q == ST_SEND) && (idx_q == cnt_q - CW'(1));

    assign bus.m_valid   = (state_q == ST_SEND);
    assign bus.m_last    = at_last;
    assign bus.m_idx     = idx_q;
    assign bus.bad_count = bad_q;
    // A new word may enter only as the final lane of the current one leaves,
    // so unsent lanes are never overwritten.
    assign bus.s_ready   = (state_q == ST_IDLE) || (bus.m_ready && at_last);

    assign accept = bus.s_valid && bus.s_ready;
    assign m_fire = bus.m_valid && bus.m_ready;

    lane_select #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .CW     (CW)
    ) u_lane_select (
        .data (buf_q),
        .idx  (idx_q),
        .lane (bus.m_data)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        bad_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_fire) begin
                    if (!at_last) begin
                        idx_d = idx_q + CW'(1);
                    end else begin
                        idx_d = '0;
                        if (!accept) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Acceptance (from IDLE or on the last-lane handoff) reloads the buffer.
        if (accept) begin
            buf_d = bus.s_data;
            cnt_d = s_eff;
            idx_d = '0;
            bad_d = s_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: tb/tb_word_unpacker.sv
// tb_word_unpacker: scoreboard bench for word_unpacker (LANE_W=4, LANES=4).
// Inputs change on the falling edge; everything is sampled 1 time unit
// before the rising edge.
module tb_word_unpacker;

    typedef struct {
        logic [3:0] d;
        int         idx;
        bit         last;
    } lane_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   n_pulse;
    bit   rnd_on;
    lane_t sb[$];

    word_unpacker_if #(.LANE_W(4), .LANES(4)) bus ();

    word_unpacker #(.LANE_W(4), .LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected lanes come straight from the word value and lane count.
    task automatic push_expected(input logic [15:0] d, input logic [2:0] c);
        int    n;
        lane_t e;
        n = (c == 0 || c > 4) ? 4 : int'(c);
        for (int k = 0; k < n; k++) begin
            e.d    = 4'((d >> (4 * k)) & 16'hF);
            e.idx  = k;
            e.last = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_word(input logic [15:0] d, input logic [2:0] c);
        bit hs;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_count = c;
        for (int t = 0; t < 300; t++) begin
            #4;
            hs = bus.s_ready;
            @(posedge clk);
            if (hs) push_expected(d, c);
            @(negedge clk);
            if (hs) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drained", sb.size(), 0);
    endtask

    // Monitor: pops expected lanes on each output transfer and checks the
    // handshake against the count of outstanding lanes.
    initial begin : monitor
        bit         prev_bad;
        bit         stall_prev;
        logic [3:0] sv_d;
        logic [2:0] sv_idx;
        logic       sv_last;
        lane_t      e;
        prev_bad   = 1'b0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                prev_bad   = 1'b0;
                stall_prev = 1'b0;
                continue;
            end
            chk("m_valid", int'(bus.m_valid), int'(sb.size() != 0));
            chk("s_ready", int'(bus.s_ready),
                (sb.size() == 0) ? 1 : int'(bus.m_ready && sb[0].last));
            chk("bad_count", int'(bus.bad_count), int'(prev_bad));
            if (bus.bad_count) n_pulse++;
            if (stall_prev) begin
                chk("stall_data", int'(bus.m_data), int'(sv_d));
                chk("stall_idx", int'(bus.m_idx), int'(sv_idx));
                chk("stall_last", int'(bus.m_last), int'(sv_last));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_lane", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("lane_data", int'(bus.m_data), int'(e.d));
                    chk("lane_idx", int'(bus.m_idx), e.idx);
                    chk("lane_last", int'(bus.m_last), int'(e.last));
                end
            end
            prev_bad   = bus.s_valid && bus.s_ready &&
                         (bus.s_count == 0 || bus.s_count > 4);
            stall_prev = bus.m_valid && !bus.m_ready;
            sv_d       = bus.m_data;
            sv_idx     = bus.m_idx;
            sv_last    = bus.m_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, int'(bus.s_ready), 1);
        chk({tag, "_m_valid"}, int'(bus.m_valid), 0);
        chk({tag, "_m_data"}, int'(bus.m_data), 0);
        chk({tag, "_m_idx"}, int'(bus.m_idx), 0);
        chk({tag, "_m_last"}, int'(bus.m_last), 0);
        chk({tag, "_bad_count"}, int'(bus.bad_count), 0);
    endtask

    initial begin : main
        int pulses0;
        n_total     = 0;
        n_bad       = 0;
        n_pulse     = 0;
        rnd_on      = 1'b0;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_count = '0;
        bus.m_ready = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single full word, consumer always ready.
        bus.m_ready = 1'b1;
        send_word(16'hA5C3, 3'd4);
        bus.s_valid = 1'b0;
        drain();

        // Two words held back to back.
        send_word(16'h1234, 3'd4);
        send_word(16'h5678, 3'd4);
        bus.s_valid = 1'b0;
        drain();

        // Stall at lane 1.
        send_word(16'hBEEF, 3'd4);
        bus.s_valid = 1'b0;
        @(negedge clk);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("stall_E_data", int'(bus.m_data), 4'hE);
            chk("stall_E_idx", int'(bus.m_idx), 1);
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        drain();

        // Short word, then a zero count treated as full with a bad_count pulse.
        pulses0 = n_pulse;
        send_word(16'hFF21, 3'd2);
        send_word(16'h4321, 3'd0);
        bus.s_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        chk("bad_pulses", n_pulse - pulses0, 1);

        // Reset in the middle of a word.
        send_word(16'h9876, 3'd4);
        bus.s_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (bus.m_valid && bus.m_idx == 2) break;
            @(negedge clk);
        end
        chk("reached_idx2", int'(bus.m_idx), 2);
        bus.m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        repeat (6) @(negedge clk);
        chk("post_rst_idle", int'(bus.m_valid), 0);

        // Random words, counts, gaps and consumer back-pressure.
        pulses0 = n_pulse;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    bus.m_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
            end
        join_none
        for (int w = 0; w < 80; w++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            send_word(16'($urandom), 3'($urandom_range(0, 7)));
        end
        bus.s_valid = 1'b0;
        rnd_on = 1'b0;
        @(negedge clk);
        #1 bus.m_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
